line_fetch_arbiter: RTL

LINE_FETCH_ARBITER -- requirements
Module: line_fetch_arbiter

---
 rtl/line_fetch_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/line_fetch_arbiter.sv
// Purpose: arbitrates prog/data line fills and write-back FIFO drains onto one 512-bit memory port.
// Latency: grant on the edge after a request; fill strobe one cycle after mem_ack (3 cycles minimum).
// Backpressure: holds mem_req and the command stable until mem_ack; the FIFO is popped only on a write grant.
//
// Optional feature macro: LINE_ARB_TIMEOUT_EN (adds a 10-bit wait-timeout counter and timeout_err).
//
// Ports:
//   dram_clk, reset            clock, async active-low reset
//   is_req_f_prog/_data        level fetch requests, req_addr_f_* 18-bit line addresses
//   fifo_empty, write_back_*   show-ahead write-back FIFO head, wb_pop read strobe
//   mem_*                      memory command/response port
//   read_*_data, *_valid       registered fill lines and one-cycle fill strobes
//   timeout_err                sticky wait-timeout flag (LINE_ARB_TIMEOUT_EN only)
`timescale 1ns/1ps
module line_fetch_arbiter (
    input  logic         dram_clk,
    input  logic         reset,
    input  logic         is_req_f_prog,
    input  logic         is_req_f_data,
    input  logic [17:0]  req_addr_f_prog,
    input  logic [17:0]  req_addr_f_data,
    input  logic         fifo_empty,
    input  logic [31:0]  write_back_data,
    input  logic [31:0]  write_back_addr,
    output logic         wb_pop,
    output logic         mem_req,
    output logic         mem_we,
    output logic [17:0]  mem_addr,
    output logic [511:0] mem_wdata,
    output logic [15:0]  mem_wmask,
    input  logic         mem_ack,
    input  logic [511:0] mem_rdata,
    output logic [511:0] read_prog_data,
    output logic [511:0] read_data_data,
    output logic         prog_valid,
    output logic         data_valid
`ifdef LINE_ARB_TIMEOUT_EN
    ,
    output logic         timeout_err
`endif
);

    typedef enum logic [1:0] {IDLE, PROG_RD, WB_WR, DATA_RD} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_arm_prog;
    logic           r_arm_data;
    logic           r_mem_we;
    logic [17:0]    r_mem_addr;
    logic [511:0]   r_mem_wdata;
    logic [15:0]    r_mem_wmask;
    logic [511:0]   r_prog_data;
    logic [511:0]   r_data_data;
    logic           r_prog_valid;
    logic           r_data_valid;
    logic           w_grant_prog;
    logic           w_grant_wb;
    logic           w_grant_data;
    logic           w_timeout;
    logic           w_done;
    logic           w_unused;

    // Only the line index and word select of the byte address matter.
    assign w_unused = ^{write_back_addr[31:24], write_back_addr[1:0]};

    // Fixed priority; a data read waits until every queued write-back has drained
    // so a fill can never return data older than a pending write.
    assign w_grant_prog = is_req_f_prog & r_arm_prog;
    assign w_grant_wb   = ~w_grant_prog & ~fifo_empty;
    assign w_grant_data = ~w_grant_prog & fifo_empty & is_req_f_data & r_arm_data;

`ifdef LINE_ARB_TIMEOUT_EN
    logic [9:0] r_wait_cnt;
    logic       r_timeout_err;

    // Fires on the cycle whose increment brings the counter to 1023.
    assign w_timeout   = (r_state != IDLE) & ~mem_ack & (r_wait_cnt == 10'd1022);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge dram_clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt    <= 10'd0;
            r_timeout_err <= 1'b0;
        end else begin
            // Held at zero while idle, so it is cleared on every grant.
            r_wait_cnt <= (r_state == IDLE) ? 10'd0 : r_wait_cnt + 10'd1;
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = mem_ack | w_timeout;

    // State register
    always_ff @(posedge dram_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_prog)      w_next = PROG_RD;
                else if (w_grant_wb)   w_next = WB_WR;
                else if (w_grant_data) w_next = DATA_RD;
            end
            default: begin
                if (w_done) w_next = IDLE;
            end
        endcase
    end

    // Output logic; the pop is gated by reset so no entry is consumed while held in reset.
    always_comb begin
        mem_req = (r_state != IDLE);
        wb_pop  = (r_state == IDLE) & w_grant_wb & reset;
    end

    // Command latch, fill capture and arm flags
    always_ff @(posedge dram_clk or negedge reset) begin
        if (!reset) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 18'd0;
            r_mem_wdata  <= 512'd0;
            r_mem_wmask  <= 16'd0;
            r_prog_data  <= 512'd0;
            r_data_data  <= 512'd0;
            r_prog_valid <= 1'b0;
            r_data_valid <= 1'b0;
            r_arm_prog   <= 1'b1;
            r_arm_data   <= 1'b1;
        end else begin
            if (r_state == IDLE) begin
                if (w_grant_prog) begin
                    r_mem_addr  <= req_addr_f_prog;
                    r_mem_we    <= 1'b0;
                    r_mem_wmask <= 16'd0;
                end else if (w_grant_wb) begin
                    r_mem_addr  <= write_back_addr[23:6];
                    r_mem_wdata <= {16{write_back_data}};
                    r_mem_wmask <= 16'd1 << write_back_addr[5:2];
                    r_mem_we    <= 1'b1;
                end else if (w_grant_data) begin
                    r_mem_addr  <= req_addr_f_data;
                    r_mem_we    <= 1'b0;
                    r_mem_wmask <= 16'd0;
                end
            end

            r_prog_valid <= (r_state == PROG_RD) & mem_ack;
            r_data_valid <= (r_state == DATA_RD) & mem_ack;
            if ((r_state == PROG_RD) && mem_ack) r_prog_data <= mem_rdata;
            if ((r_state == DATA_RD) && mem_ack) r_data_data <= mem_rdata;

            // Disarm on completion (fill or timeout); re-arm once the request is seen low,
            // so a request held high is served exactly once.
            if ((r_state == PROG_RD) && w_done) r_arm_prog <= 1'b0;
            else if (!is_req_f_prog)            r_arm_prog <= 1'b1;
            if ((r_state == DATA_RD) && w_done) r_arm_data <= 1'b0;
            else if (!is_req_f_data)            r_arm_data <= 1'b1;
        end
    end

    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wmask      = r_mem_wmask;
    assign read_prog_data = r_prog_data;
    assign read_data_data = r_data_data;
    assign prog_valid     = r_prog_valid;
    assign data_valid     = r_data_valid;

endmodule
